// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/DECODE/EXEC/ZLATCH/WB control FSM for a register datapath.
// Optional immediate ops (ADDI/ANDI/ORI) are enabled by defining CTRL_IMM_EN.
module control_sequencer (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iMemData,
  input  logic        iMemValid,
  output logic        oPC_nRst,
  output logic        oPC_en,
  output logic        oMUX_MAP,
  output logic [3:0]  oRF_AddrA,
  output logic [3:0]  oRF_AddrB,
  output logic [3:0]  oRF_AddrC,
  output logic        oRF_Write,
  output logic        oRA_en,
  output logic        oRB_en,
  output logic        oRZH_en,
  output logic        oRZL_en,
  output logic        oRWB_en,
  output logic [3:0]  oALU_Ctrl,
  output logic        oMUX_BIS,
  output logic        oMUX_RZHS,
  output logic        oMUX_WBM,
  output logic [31:0] oImm32,
  output logic        oHalted,
  output logic        oIllegal
);

  localparam int unsigned IR_W  = 32;
  localparam int unsigned OP_W  = 5;
  localparam int unsigned REG_W = 4;
  localparam int unsigned ALU_W = 4;

  localparam logic [OP_W-1:0] ISA_ADD  = 5'h01;
  localparam logic [OP_W-1:0] ISA_SUB  = 5'h02;
  localparam logic [OP_W-1:0] ISA_AND  = 5'h03;
  localparam logic [OP_W-1:0] ISA_OR   = 5'h04;
  localparam logic [OP_W-1:0] ISA_XOR  = 5'h05;
  localparam logic [OP_W-1:0] ISA_SLL  = 5'h06;
  localparam logic [OP_W-1:0] ISA_SRL  = 5'h07;
  localparam logic [OP_W-1:0] ISA_ROL  = 5'h08;
  localparam logic [OP_W-1:0] ISA_ROR  = 5'h09;
  localparam logic [OP_W-1:0] ISA_ADDI = 5'h0A;
  localparam logic [OP_W-1:0] ISA_ANDI = 5'h0B;
  localparam logic [OP_W-1:0] ISA_ORI  = 5'h0C;
  localparam logic [OP_W-1:0] ISA_HALT = 5'h1F;

  localparam logic [ALU_W-1:0] CTRL_ALU_ADD = 4'h0;
  localparam logic [ALU_W-1:0] CTRL_ALU_SUB = 4'h1;
  localparam logic [ALU_W-1:0] CTRL_ALU_AND = 4'h2;
  localparam logic [ALU_W-1:0] CTRL_ALU_OR  = 4'h3;
  localparam logic [ALU_W-1:0] CTRL_ALU_XOR = 4'h4;
  localparam logic [ALU_W-1:0] CTRL_ALU_SLL = 4'h5;
  localparam logic [ALU_W-1:0] CTRL_ALU_SRL = 4'h6;
  localparam logic [ALU_W-1:0] CTRL_ALU_ROL = 4'h7;
  localparam logic [ALU_W-1:0] CTRL_ALU_ROR = 4'h8;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ZLATCH, S_WB, S_TRAP, S_HALT
  } state_t;

  typedef struct packed {
    logic             pc_nrst;
    logic             mux_map;
    logic [REG_W-1:0] rf_addr_a;
    logic [REG_W-1:0] rf_addr_b;
    logic [REG_W-1:0] rf_addr_c;
    logic             rf_write;
    logic             ra_en;
    logic             rb_en;
    logic             rzh_en;
    logic             rzl_en;
    logic             rwb_en;
    logic [ALU_W-1:0] alu_ctrl;
    logic             mux_bis;
    logic [IR_W-1:0]  imm32;
    logic             halted;
    logic             illegal;
  } ctrl_out_t;

  // Returns {legal, immediate, alu_ctrl} for an opcode.
  function automatic logic [ALU_W+1:0] op_decode(input logic [OP_W-1:0] op);
    logic [ALU_W+1:0] r;
    r = '0;
    case (op)
      ISA_ADD:  r = {2'b10, CTRL_ALU_ADD};
      ISA_SUB:  r = {2'b10, CTRL_ALU_SUB};
      ISA_AND:  r = {2'b10, CTRL_ALU_AND};
      ISA_OR:   r = {2'b10, CTRL_ALU_OR};
      ISA_XOR:  r = {2'b10, CTRL_ALU_XOR};
      ISA_SLL:  r = {2'b10, CTRL_ALU_SLL};
      ISA_SRL:  r = {2'b10, CTRL_ALU_SRL};
      ISA_ROL:  r = {2'b10, CTRL_ALU_ROL};
      ISA_ROR:  r = {2'b10, CTRL_ALU_ROR};
`ifdef CTRL_IMM_EN
      ISA_ADDI: r = {2'b11, CTRL_ALU_ADD};
      ISA_ANDI: r = {2'b11, CTRL_ALU_AND};
      ISA_ORI:  r = {2'b11, CTRL_ALU_OR};
`endif
      default:  r = '0;
    endcase
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  ctrl_out_t       out_q, out_d;
  logic            pc_en_c;
  logic            dec_legal, dec_imm;
  logic [ALU_W-1:0] dec_alu;

  // pc_nrst_q is low only in the cycle after a reset edge, so no fetch is accepted then.
  assign pc_en_c = (state_q == S_FETCH) && iMemValid && out_q.pc_nrst && !iRst;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    out_d   = '0;
    out_d.pc_nrst = 1'b1;

    case (state_q)
      S_FETCH: begin
        if (pc_en_c) begin
          ir_d    = iMemData;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q[31:27] == ISA_HALT)           state_d = S_HALT;
        else if (!op_decode(ir_q[31:27])[ALU_W+1]) state_d = S_TRAP;
        else                                     state_d = S_EXEC;
      end
      S_EXEC:   state_d = S_ZLATCH;
      S_ZLATCH: state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase

    // Outputs are registered: computed for the state being entered.
    {dec_legal, dec_imm, dec_alu} = op_decode(ir_d[31:27]);
    if (dec_legal && (state_d inside {S_DECODE, S_EXEC, S_ZLATCH, S_WB})) begin
      out_d.rf_addr_a = ir_d[22:19];
      out_d.rf_addr_b = ir_d[18:15];
      out_d.alu_ctrl  = dec_alu;
    end

    case (state_d)
      S_FETCH:  out_d.mux_map = 1'b1;
      S_DECODE: begin
        out_d.ra_en = dec_legal;
        out_d.rb_en = dec_legal && !dec_imm;
      end
      S_EXEC: begin
        out_d.rzh_en = 1'b1;
        out_d.rzl_en = 1'b1;
`ifdef CTRL_IMM_EN
        out_d.mux_bis = dec_imm;
        if (dec_imm) out_d.imm32 = {{13{ir_d[18]}}, ir_d[18:0]};
`endif
      end
      S_ZLATCH: out_d.rwb_en = 1'b1;
      S_WB: begin
        out_d.rf_addr_c = ir_d[26:23];
        out_d.rf_write  = 1'b1;
      end
      S_TRAP:   out_d.illegal = 1'b1;
      S_HALT:   out_d.halted  = 1'b1;
      default:  out_d.mux_map = 1'b0;
    endcase
  end

`ifndef CTRL_IMM_EN
  logic unused_ir_lo;
  assign unused_ir_lo = ^ir_d[14:0];
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      out_q   <= out_d;
    end
  end

  assign oPC_nRst  = out_q.pc_nrst;
  assign oPC_en    = pc_en_c;
  assign oMUX_MAP  = out_q.mux_map;
  assign oRF_AddrA = out_q.rf_addr_a;
  assign oRF_AddrB = out_q.rf_addr_b;
  assign oRF_AddrC = out_q.rf_addr_c;
  assign oRF_Write = out_q.rf_write;
  assign oRA_en    = out_q.ra_en;
  assign oRB_en    = out_q.rb_en;
  assign oRZH_en   = out_q.rzh_en;
  assign oRZL_en   = out_q.rzl_en;
  assign oRWB_en   = out_q.rwb_en;
  assign oALU_Ctrl = out_q.alu_ctrl;
  assign oMUX_BIS  = out_q.mux_bis;
  assign oMUX_RZHS = 1'b0;
  assign oMUX_WBM  = 1'b0;
  assign oImm32    = out_q.imm32;
  assign oHalted   = out_q.halted;
  assign oIllegal  = out_q.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random instructions
// checked cycle by cycle against a phase-based reference model.
module tb_control_sequencer;

  localparam logic [4:0] ISA_ROL  = 5'h08;
  localparam logic [4:0] ISA_ADDI = 5'h0A;
  localparam logic [4:0] ISA_ANDI = 5'h0B;
  localparam logic [4:0] ISA_ORI  = 5'h0C;
  localparam logic [4:0] ISA_HALT = 5'h1F;

  localparam int K_ILL = 0, K_R = 1, K_IMM = 2, K_HALT = 3;
  localparam int PH_RST = 0, PH_FETCH = 1, PH_DEC = 2, PH_EXEC = 3, PH_ZL = 4,
                 PH_WB = 5, PH_TRAP = 6, PH_HALT = 7;

  logic        iClk, iRst, iMemValid;
  logic [31:0] iMemData;
  logic        oPC_nRst, oPC_en, oMUX_MAP, oRF_Write, oRA_en, oRB_en;
  logic        oRZH_en, oRZL_en, oRWB_en, oMUX_BIS, oMUX_RZHS, oMUX_WBM, oHalted, oIllegal;
  logic [3:0]  oRF_AddrA, oRF_AddrB, oRF_AddrC, oALU_Ctrl;
  logic [31:0] oImm32;
  logic [63:0] obs;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;

  control_sequencer dut (
    .iClk(iClk), .iRst(iRst), .iMemData(iMemData), .iMemValid(iMemValid),
    .oPC_nRst(oPC_nRst), .oPC_en(oPC_en), .oMUX_MAP(oMUX_MAP),
    .oRF_AddrA(oRF_AddrA), .oRF_AddrB(oRF_AddrB), .oRF_AddrC(oRF_AddrC),
    .oRF_Write(oRF_Write), .oRA_en(oRA_en), .oRB_en(oRB_en), .oRZH_en(oRZH_en),
    .oRZL_en(oRZL_en), .oRWB_en(oRWB_en), .oALU_Ctrl(oALU_Ctrl), .oMUX_BIS(oMUX_BIS),
    .oMUX_RZHS(oMUX_RZHS), .oMUX_WBM(oMUX_WBM), .oImm32(oImm32),
    .oHalted(oHalted), .oIllegal(oIllegal)
  );

  assign obs = {3'b0, oPC_nRst, oMUX_MAP, oRF_AddrA, oRF_AddrB, oRF_AddrC, oRF_Write,
                oRA_en, oRB_en, oRZH_en, oRZL_en, oRWB_en, oALU_Ctrl, oMUX_BIS,
                oMUX_RZHS, oMUX_WBM, oHalted, oIllegal, oImm32};

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  always @(posedge iClk) if (oRF_Write === 1'b1) n_writes <= n_writes + 1;

  // Opcode classes: 1..9 are register ALU ops in order ADD,SUB,AND,OR,XOR,SLL,SRL,ROL,ROR.
  function automatic void classify(input logic [4:0] op, output int kind, output logic [3:0] alu);
    kind = K_ILL;
    alu  = 4'h0;
    if (op == ISA_HALT) kind = K_HALT;
    else if (op >= 5'h01 && op <= 5'h09) begin
      kind = K_R;
      alu  = 4'(op - 5'h01);
    end
`ifdef CTRL_IMM_EN
    else if (op == ISA_ADDI) begin kind = K_IMM; alu = 4'h0; end
    else if (op == ISA_ANDI) begin kind = K_IMM; alu = 4'h2; end
    else if (op == ISA_ORI)  begin kind = K_IMM; alu = 4'h3; end
`endif
  endfunction

  function automatic logic [63:0] exp_vec(input int ph, input logic [31:0] w);
    int kind;
    logic [3:0] alu, a, b, c, ac;
    logic nrst, map, wr, raen, rben, rzh, rzl, rwb, bis, hlt, ill;
    logic [31:0] imm;
    logic active;
    classify(w[31:27], kind, alu);
    nrst = (ph != PH_RST);
    {map, wr, raen, rben, rzh, rzl, rwb, bis, hlt, ill} = '0;
    {a, b, c, ac} = '0;
    imm = 32'h0;
    active = (kind == K_R || kind == K_IMM) && (ph >= PH_DEC) && (ph <= PH_WB);
    if (active) begin
      a = w[22:19]; b = w[18:15]; ac = alu;
    end
    case (ph)
      PH_FETCH: map = 1'b1;
      PH_DEC:   begin raen = active; rben = active && (kind == K_R); end
      PH_EXEC:  begin
        rzh = 1'b1; rzl = 1'b1;
        if (kind == K_IMM) begin bis = 1'b1; imm = 32'(signed'(w[18:0])); end
      end
      PH_ZL:    rwb = 1'b1;
      PH_WB:    begin c = w[26:23]; wr = 1'b1; end
      PH_TRAP:  ill = 1'b1;
      PH_HALT:  hlt = 1'b1;
      default:  map = 1'b0;
    endcase
    return {3'b0, nrst, map, a, b, c, wr, raen, rben, rzh, rzl, rwb, ac, bis,
            1'b0, 1'b0, hlt, ill, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Cycle-level check of one instruction starting in FETCH; HALT stops after entering HALT.
  task automatic run_instr(input logic [31:0] w, input int stalls, input string tag);
    int kind, wr0, nph;
    int ph[4];
    logic [3:0] alu;
    classify(w[31:27], kind, alu);
    wr0 = n_writes;
    for (int s = 0; s < stalls; s++) begin
      iMemValid = 1'b0; iMemData = $urandom; #1;
      chk({tag, "_stall"}, obs, exp_vec(PH_FETCH, w));
      chk({tag, "_stall_pcen"}, 64'(oPC_en), 64'd0);
      tick();
    end
    iMemValid = 1'b1; iMemData = w; #1;
    chk({tag, "_fetch"}, obs, exp_vec(PH_FETCH, w));
    chk({tag, "_fetch_pcen"}, 64'(oPC_en), 64'd1);
    tick();
    if (kind == K_R || kind == K_IMM) begin
      ph = '{PH_DEC, PH_EXEC, PH_ZL, PH_WB}; nph = 4;
    end else if (kind == K_ILL) begin
      ph = '{PH_DEC, PH_TRAP, 0, 0}; nph = 2;
    end else begin
      ph = '{PH_DEC, 0, 0, 0}; nph = 1;
    end
    for (int i = 0; i < nph; i++) begin
      iMemValid = 1'($urandom); iMemData = $urandom; #1;
      chk($sformatf("%s_ph%0d", tag, ph[i]), obs, exp_vec(ph[i], w));
      chk($sformatf("%s_ph%0d_pcen", tag, ph[i]), 64'(oPC_en), 64'd0);
      tick();
    end
    if (kind != K_HALT) begin
      iMemValid = 1'b0; #1;
      chk({tag, "_next_fetch"}, obs, exp_vec(PH_FETCH, w));
      chk({tag, "_writes"}, 64'(n_writes - wr0), (kind == K_ILL) ? 64'd0 : 64'd1);
    end
  endtask

  logic [31:0] w;

  initial begin
    iRst = 1'b1; iMemValid = 1'b0; iMemData = 32'h0;
    tick(); tick();
    chk("reset_outputs", obs, exp_vec(PH_RST, 32'h0));
    chk("reset_pcen", 64'(oPC_en), 64'd0);
    iRst = 1'b0;
    tick();
    chk("post_reset_fetch", obs, exp_vec(PH_FETCH, 32'h0));

    // ROL R4,R3,R7 with no stall, then with 3 stall cycles
    w = {ISA_ROL, 4'd4, 4'd3, 4'd7, 15'h0};
    run_instr(w, 0, "rol");
    chk("rol_alu_code", 64'(oALU_Ctrl), 64'd0);
    run_instr(w, 3, "rol_stall3");

    // unmapped opcode
    run_instr({5'b11110, 27'h2A5_5A5}, 0, "illegal");

    // immediate add: legal with CTRL_IMM_EN, illegal otherwise
    run_instr({ISA_ADDI, 4'd2, 4'd5, 19'h7FFFF}, 1, "addi");

    // random instructions (HALT excluded)
    for (int k = 0; k < 40; k++) begin
      w = {5'($urandom_range(0, 30)), 27'($urandom)};
      run_instr(w, $urandom_range(0, 3), $sformatf("rnd%0d", k));
    end

    // reset asserted during EXEC aborts the write
    begin
      int wr0;
      wr0 = n_writes;
      w = {ISA_ROL, 4'd9, 4'd1, 4'd2, 15'h0};
      iMemValid = 1'b1; iMemData = w; #1;
      tick();
      iMemValid = 1'b1; #1;
      chk("abort_decode", obs, exp_vec(PH_DEC, w));
      tick();
      chk("abort_exec", obs, exp_vec(PH_EXEC, w));
      iRst = 1'b1;
      tick();
      #1;
      chk("abort_reset_outputs", obs, exp_vec(PH_RST, w));
      chk("abort_reset_pcen", 64'(oPC_en), 64'd0);
      iRst = 1'b0; iMemValid = 1'b0;
      tick();
      chk("abort_after_reset", obs, exp_vec(PH_FETCH, w));
      chk("abort_writes", 64'(n_writes - wr0), 64'd0);
    end

    // HALT holds with iMemValid high until reset
    w = {ISA_HALT, 27'h123_4567};
    run_instr(w, 0, "halt");
    for (int i = 0; i < 22; i++) begin
      iMemValid = 1'b1; iMemData = $urandom; #1;
      chk($sformatf("halted_%0d", i), obs, exp_vec(PH_HALT, w));
      chk($sformatf("halted_pcen_%0d", i), 64'(oPC_en), 64'd0);
      tick();
    end
    iRst = 1'b1;
    tick();
    chk("halt_reset_outputs", obs, exp_vec(PH_RST, w));
    iRst = 1'b0; iMemValid = 1'b0;
    tick();
    chk("halt_released", obs, exp_vec(PH_FETCH, w));
    run_instr({ISA_ROL, 4'd1, 4'd2, 4'd3, 15'h0}, 0, "after_halt");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
